// File: rtl/start_fifo_srl_ctrl_pkg.sv
// start_fifo_srl_ctrl_pkg: FIFO parameter defaults, clog2 helper and occupancy width helper
package start_fifo_srl_ctrl_pkg;
  localparam int DATA_WIDTH_DEF = 1;
  localparam int DEPTH_DEF = 2;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
  localparam int ADDR_WIDTH_DEF = clog2(DEPTH_DEF);
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction
endpackage

// File: rtl/start_fifo_srl_ctrl_if.sv
// start_fifo_srl_ctrl_if: HLS FIFO handshake bundle; slave = FIFO (drives full_n/empty_n/dout/num_data), master = producer+consumer
interface start_fifo_srl_ctrl_if #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1
);
  logic                  if_full_n;
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_empty_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic [ADDR_WIDTH:0]   if_num_data;
  modport slave (
    output if_full_n, if_empty_n, if_dout, if_num_data,
    input  if_write_ce, if_write, if_din, if_read_ce, if_read
  );
  modport master (
    input  if_full_n, if_empty_n, if_dout, if_num_data,
    output if_write_ce, if_write, if_din, if_read_ce, if_read
  );
endinterface

// File: rtl/start_fifo_srl_ctrl_storage.sv
// start_fifo_srl_storage: unreset DEPTH x DATA_WIDTH shift array; we shifts din into slot 0, dout = mem[addr]
module start_fifo_srl_storage #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end
  assign dout = (int'(addr) < DEPTH) ? mem[addr] : '0;
endmodule

// File: rtl/start_fifo_srl_ctrl.sv
// start_fifo_srl_ctrl: SRL start-token FIFO control; ports clk, reset, f (slave: full_n/write_ce/write/din, empty_n/read_ce/read/dout, num_data)
module start_fifo_srl_ctrl
  import start_fifo_srl_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic clk,
  input logic reset,
  start_fifo_srl_ctrl_if.slave f
);
  localparam int CW = cnt_width(ADDR_WIDTH);
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  empty_n_q, empty_n_d, full_n_q, full_n_d;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] dout;
  always_comb begin
    push = f.if_write & f.if_write_ce & full_n_q;
    pop = f.if_read & f.if_read_ce & empty_n_q;
    cnt_d = (push & ~pop) ? cnt_q + 1'b1 : (pop & ~push) ? cnt_q - 1'b1 : cnt_q;
    addr_d = (cnt_d == '0) ? '0 : ADDR_WIDTH'(cnt_d - 1'b1);
    empty_n_d = cnt_d != '0;
    full_n_d = cnt_d != CW'(DEPTH);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      addr_q <= '0;
      empty_n_q <= 1'b0;
      full_n_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      empty_n_q <= empty_n_d;
      full_n_q <= full_n_d;
    end
  end
  start_fifo_srl_storage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH(DEPTH)
  ) u_storage (
    .clk(clk),
    .we(push),
    .addr(addr_q),
    .din(f.if_din),
    .dout(dout)
  );
  assign f.if_full_n = full_n_q;
  assign f.if_empty_n = empty_n_q;
  assign f.if_dout = dout;
  assign f.if_num_data = cnt_q;
endmodule
